// File: rtl/inst_fetcher.sv
// -----------------------------------------------------------------------------
// inst_fetcher
//
// Fetch stage of the out-of-order RISC-V core. Holds the architectural fetch
// PC, requests one instruction word at a time from the memory controller,
// queries the branch predictor combinationally with each returned word and
// steers the PC to the predicted target or PC+4. Fetched entries
// {pc, inst, predicted-jump} go into a circular instruction queue that the
// decoder drains through a valid/ready handshake. A ROB rollback flushes the
// queue and restarts fetch at the corrected PC.
//
// Optional feature (macro FETCHER_ICACHE_EN): a direct-mapped cache of
// ICACHE_LINES one-word lines (index pc[7:2], tag pc[31:8]). A hit in IDLE
// pushes the cached word straight into the queue, giving one fetch per cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes every register
//   mem_req_valid/addr  fetch request to the memory controller
//   mem_rsp_valid/inst  one-cycle response pulse with the instruction word
//   pred_pc/pred_inst   fetch presented to the branch predictor
//   pred_jump/offset    predictor verdict and sign-extended immediate
//   iq_out_*            queue head towards the decoder (valid/ready)
//   rollback/_pc        misprediction flush and restart PC
// -----------------------------------------------------------------------------
module inst_fetcher #(
  parameter int          IQ_DEPTH     = 16,
  parameter int          IQ_PTR_W     = 4,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_inst,
  output logic [31:0] pred_pc,
  output logic [31:0] pred_inst,
  input  logic        pred_jump,
  input  logic [31:0] pred_offset,
  output logic        iq_out_valid,
  input  logic        iq_out_ready,
  output logic [31:0] iq_out_pc,
  output logic [31:0] iq_out_inst,
  output logic        iq_out_pred_jump,
  input  logic        rollback,
  input  logic [31:0] rollback_pc
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_DRAIN    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_req_valid;
  logic        w_req_valid_next;
  logic [31:0] r_req_addr;
  logic [31:0] w_req_addr_next;

  logic [31:0] r_iq_pc   [IQ_DEPTH];
  logic [31:0] r_iq_inst [IQ_DEPTH];
  logic        r_iq_jump [IQ_DEPTH];
  logic [IQ_PTR_W-1:0] r_head;
  logic [IQ_PTR_W-1:0] r_tail;
  logic [IQ_PTR_W:0]   r_count;

  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_pc_pred;
  logic        w_ic_fetch;
  logic [31:0] w_ic_word;

  assign w_full       = (r_count == (IQ_PTR_W+1)'(IQ_DEPTH));
  assign iq_out_valid = (r_count != '0);

  // The predictor result is only meaningful while a fetch is being presented;
  // the sum wraps naturally modulo 2^32.
  assign w_pc_pred = pred_jump ? (r_pc + pred_offset) : (r_pc + 32'd4);

  // The predictor sees the current PC with either the memory word or, on a
  // cache hit, the cached word. Otherwise both buses idle at zero.
  assign pred_pc   = (mem_rsp_valid || w_ic_fetch) ? r_pc : 32'd0;
  assign pred_inst = mem_rsp_valid ? mem_rsp_inst :
                     (w_ic_fetch ? w_ic_word : 32'd0);

`ifdef FETCHER_ICACHE_EN
  logic [31:0]             r_ic_data [ICACHE_LINES];
  logic [23:0]             r_ic_tag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] r_ic_valid;
  logic [5:0]              w_ic_idx;
  logic                    w_ic_hit;
  logic                    w_fill;

  assign w_ic_idx   = r_pc[7:2];
  assign w_ic_hit   = r_ic_valid[w_ic_idx] && (r_ic_tag[w_ic_idx] == r_pc[31:8]);
  assign w_ic_fetch = (r_state == S_IDLE) && !w_full && w_ic_hit;
  assign w_ic_word  = r_ic_data[w_ic_idx];

  // Only a response that is actually queued fills the line; words dropped by
  // a rollback or discarded in DRAIN never reach the cache.
  assign w_fill = rdy && !rollback && (r_state == S_WAIT_MEM) && mem_rsp_valid;

  // Valid bits survive rollbacks: the cached words stay correct memory
  // contents regardless of control-flow redirection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ic_valid <= '0;
    end else if (w_fill) begin
      r_ic_valid[w_ic_idx] <= 1'b1;
    end
  end

  // Data and tag arrays need no reset; they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_ic_data[w_ic_idx] <= mem_rsp_inst;
      r_ic_tag[w_ic_idx]  <= r_pc[31:8];
    end
  end
`else
  logic [31:0] w_unused_icache_lines;

  assign w_unused_icache_lines = 32'(ICACHE_LINES);
  assign w_ic_fetch            = 1'b0;
  assign w_ic_word             = 32'd0;
`endif

  // FSM state and fetch-control registers. rdy only gates the update; the
  // next-state logic below already leaves everything unchanged when rdy=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_addr  <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_req_valid <= w_req_valid_next;
      r_req_addr  <= w_req_addr_next;
    end
  end

  // Next-state logic. Rollback is checked first in every state. The request
  // is registered, so a response is always followed by one IDLE cycle before
  // the next request becomes visible.
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_req_valid_next = r_req_valid;
    w_req_addr_next  = r_req_addr;
    w_push           = 1'b0;

    if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (rollback) begin
            w_pc_next        = rollback_pc;
            w_req_valid_next = 1'b0;
          end else if (w_ic_fetch) begin
            w_push    = 1'b1;
            w_pc_next = w_pc_pred;
          end else if (!w_full) begin
            w_req_valid_next = 1'b1;
            w_req_addr_next  = r_pc;
            w_state_next     = S_WAIT_MEM;
          end
        end

        S_WAIT_MEM: begin
          if (rollback) begin
            // A response arriving together with the rollback is simply
            // dropped; otherwise the in-flight word must still be absorbed.
            w_pc_next        = rollback_pc;
            w_req_valid_next = 1'b0;
            w_state_next     = mem_rsp_valid ? S_IDLE : S_DRAIN;
          end else if (mem_rsp_valid) begin
            w_push           = 1'b1;
            w_pc_next        = w_pc_pred;
            w_req_valid_next = 1'b0;
            w_state_next     = S_IDLE;
          end
        end

        S_DRAIN: begin
          w_req_valid_next = 1'b0;
          if (rollback) begin
            w_pc_next = rollback_pc;
          end
          if (mem_rsp_valid) begin
            w_state_next = S_IDLE;
          end
        end

        default: begin
          w_state_next     = S_IDLE;
          w_req_valid_next = 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;

  // Pops are suppressed during a rollback because the flush wins anyway.
  assign w_pop = rdy && !rollback && iq_out_valid && iq_out_ready;

  // Queue pointers and occupancy. Pointers are IQ_PTR_W bits wide, so they
  // wrap from IQ_DEPTH-1 to 0 on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (rollback) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage. Entries are only ever read under iq_out_valid, so they
  // need no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_iq_pc[r_tail]   <= r_pc;
      r_iq_inst[r_tail] <= pred_inst;
      r_iq_jump[r_tail] <= pred_jump;
    end
  end

  assign iq_out_pc        = iq_out_valid ? r_iq_pc[r_head]   : 32'd0;
  assign iq_out_inst      = iq_out_valid ? r_iq_inst[r_head] : 32'd0;
  assign iq_out_pred_jump = iq_out_valid ? r_iq_jump[r_head] : 1'b0;

endmodule

// File: tb/tb_inst_fetcher.sv
// -----------------------------------------------------------------------------
// tb_inst_fetcher
//
// Self-checking bench for inst_fetcher: a cycle-by-cycle vector table for
// the basic fetch/predict/pop flow, followed by hand-written sequences for
// queue-full, pointer wrap, rollback variants, mid-run reset and (when built
// with FETCHER_ICACHE_EN) cache hits.
// -----------------------------------------------------------------------------
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_inst;
  logic [31:0] pred_pc;
  logic [31:0] pred_inst;
  logic        pred_jump;
  logic [31:0] pred_offset;
  logic        iq_out_valid;
  logic        iq_out_ready;
  logic [31:0] iq_out_pc;
  logic [31:0] iq_out_inst;
  logic        iq_out_pred_jump;
  logic        rollback;
  logic [31:0] rollback_pc;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic        rdy;
    logic        rspValid;
    logic [31:0] rspInst;
    logic        predJump;
    logic [31:0] predOffset;
    logic        ready;
    logic        expReqValid;
    logic [31:0] expReqAddr;
    logic        expIqValid;
    logic [31:0] expIqPc;
    logic [31:0] expIqInst;
    logic        expIqJump;
    logic [31:0] expPredPc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  inst_fetcher #(
    .IQ_DEPTH(16),
    .IQ_PTR_W(4),
    .RESET_PC(32'h0),
    .ICACHE_LINES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_inst(mem_rsp_inst),
    .pred_pc(pred_pc),
    .pred_inst(pred_inst),
    .pred_jump(pred_jump),
    .pred_offset(pred_offset),
    .iq_out_valid(iq_out_valid),
    .iq_out_ready(iq_out_ready),
    .iq_out_pc(iq_out_pc),
    .iq_out_inst(iq_out_inst),
    .iq_out_pred_jump(iq_out_pred_jump),
    .rollback(rollback),
    .rollback_pc(rollback_pc)
  );

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic addRow(input logic r, input logic v, input logic [31:0] inst,
                        input logic j, input logic [31:0] off, input logic rd,
                        input logic eReq, input logic [31:0] eAddr,
                        input logic eIq, input logic [31:0] ePc,
                        input logic [31:0] eInst, input logic eJ,
                        input logic [31:0] ePred);
    vec_t v_row;
    v_row.rdy = r;          v_row.rspValid = v;     v_row.rspInst = inst;
    v_row.predJump = j;     v_row.predOffset = off; v_row.ready = rd;
    v_row.expReqValid = eReq; v_row.expReqAddr = eAddr;
    v_row.expIqValid = eIq; v_row.expIqPc = ePc;    v_row.expIqInst = eInst;
    v_row.expIqJump = eJ;   v_row.expPredPc = ePred;
    vecs.push_back(v_row);
  endtask

  task automatic applyStimulus(input vec_t v);
    rdy           = v.rdy;
    mem_rsp_valid = v.rspValid;
    mem_rsp_inst  = v.rspInst;
    pred_jump     = v.predJump;
    pred_offset   = v.predOffset;
    iq_out_ready  = v.ready;
  endtask

  task automatic idleInputs();
    rdy           = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_inst  = 32'd0;
    pred_jump     = 1'b0;
    pred_offset   = 32'd0;
    iq_out_ready  = 1'b0;
    rollback      = 1'b0;
    rollback_pc   = 32'd0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Wait (bounded) until a fetch request is visible.
  task automatic waitReq(input string name);
    int n = 0;
    while (mem_req_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (mem_req_valid !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: mem_req_valid got 0 after 40 cycles, expected 1", name);
    end
  endtask

  // Acts as the memory controller for one request: checks the address,
  // responds after 'latency' cycles and checks the predictor presentation.
  task automatic serveFetch(input string name, input logic [31:0] expAddr,
                            input logic [31:0] inst, input logic jump,
                            input logic [31:0] offset, input int latency,
                            input logic popOnRsp);
    waitReq(name);
    checkOutput({name, ".addr"}, mem_req_addr, expAddr);
    repeat (latency) step();
    mem_rsp_valid = 1'b1;
    mem_rsp_inst  = inst;
    pred_jump     = jump;
    pred_offset   = offset;
    if (popOnRsp) iq_out_ready = 1'b1;
    #1;
    checkOutput({name, ".predPc"}, pred_pc, expAddr);
    checkOutput({name, ".predInst"}, pred_inst, inst);
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_inst  = 32'd0;
    pred_jump     = 1'b0;
    pred_offset   = 32'd0;
    if (popOnRsp) iq_out_ready = 1'b0;
  endtask

  function automatic logic [31:0] instFor(input int k);
    return {k[11:0], 20'h00013};
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy;

    // Cycle-by-cycle table starting right after reset. Columns:
    // rdy rsp inst jump offset ready | req addr iqV iqPc iqInst iqJ predPc
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b0,32'h00, 1'b0,32'h00,32'h0,1'b0, 32'h00);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b1,32'h00, 1'b0,32'h00,32'h0,1'b0, 32'h00);
    addRow(1'b0,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b1,32'h00, 1'b0,32'h00,32'h0,1'b0, 32'h00);
    addRow(1'b1,1'b1,32'h00000013,1'b0,32'h0,1'b0, 1'b1,32'h00, 1'b0,32'h00,32'h0,1'b0, 32'h00);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b0,32'h00, 1'b1,32'h00,32'h13,1'b0, 32'h00);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b1,32'h04, 1'b1,32'h00,32'h13,1'b0, 32'h00);
    addRow(1'b1,1'b1,32'h11111113,1'b0,32'h0,1'b0, 1'b1,32'h04, 1'b1,32'h00,32'h13,1'b0, 32'h04);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b0,32'h04, 1'b1,32'h00,32'h13,1'b0, 32'h00);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b1,32'h08, 1'b1,32'h00,32'h13,1'b0, 32'h00);
    addRow(1'b1,1'b1,32'h22222213,1'b0,32'h0,1'b0, 1'b1,32'h08, 1'b1,32'h00,32'h13,1'b0, 32'h08);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b0,32'h08, 1'b1,32'h00,32'h13,1'b0, 32'h00);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b1,32'h0C, 1'b1,32'h00,32'h13,1'b0, 32'h00);
    addRow(1'b1,1'b1,32'h33333313,1'b0,32'h0,1'b0, 1'b1,32'h0C, 1'b1,32'h00,32'h13,1'b0, 32'h0C);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b0,32'h0C, 1'b1,32'h00,32'h13,1'b0, 32'h00);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b1,32'h10, 1'b1,32'h00,32'h13,1'b0, 32'h00);
    addRow(1'b1,1'b1,32'h0200006F,1'b1,32'h20,1'b0, 1'b1,32'h10, 1'b1,32'h00,32'h13,1'b0, 32'h10);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b0,32'h10, 1'b1,32'h00,32'h13,1'b0, 32'h00);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h30, 1'b1,32'h04,32'h11111113,1'b0, 32'h00);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h30, 1'b1,32'h08,32'h22222213,1'b0, 32'h00);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h30, 1'b1,32'h0C,32'h33333313,1'b0, 32'h00);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h30, 1'b1,32'h10,32'h0200006F,1'b1, 32'h00);
    addRow(1'b1,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b1,32'h30, 1'b0,32'h00,32'h0,1'b0, 32'h00);

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d.reqValid", i), {31'd0, mem_req_valid}, {31'd0, vecs[i].expReqValid});
      checkOutput($sformatf("vec%0d.reqAddr", i), mem_req_addr, vecs[i].expReqAddr);
      checkOutput($sformatf("vec%0d.iqValid", i), {31'd0, iq_out_valid}, {31'd0, vecs[i].expIqValid});
      checkOutput($sformatf("vec%0d.iqPc", i), iq_out_pc, vecs[i].expIqPc);
      checkOutput($sformatf("vec%0d.iqInst", i), iq_out_inst, vecs[i].expIqInst);
      checkOutput($sformatf("vec%0d.iqJump", i), {31'd0, iq_out_pred_jump}, {31'd0, vecs[i].expIqJump});
      checkOutput($sformatf("vec%0d.predPc", i), pred_pc, vecs[i].expPredPc);
      step();
    end

    // Rollback in IDLE to 0x10, then a backward branch wrapping to 0x00.
    doReset();
    rollback = 1'b1;
    rollback_pc = 32'h10;
    step();
    rollback = 1'b0;
    checkOutput("rbIdle.reqValid", {31'd0, mem_req_valid}, 32'd0);
    serveFetch("negBranch", 32'h10, 32'hFE000AE3, 1'b1, 32'hFFFFFFF0, 2, 1'b0);
    checkOutput("negBranch.gap", {31'd0, mem_req_valid}, 32'd0);
    step();
    checkOutput("negBranch.nextValid", {31'd0, mem_req_valid}, 32'd1);
    checkOutput("negBranch.nextAddr", mem_req_addr, 32'h0);
    checkOutput("negBranch.entryJump", {31'd0, iq_out_pred_jump}, 32'd1);

    // Fill the queue: no request while full, one pop re-enables fetch.
    doReset();
    for (int k = 0; k < 16; k++) begin
      serveFetch($sformatf("full%0d", k), 32'(4 * k), instFor(k), 1'b0, 32'h0, 1, 1'b0);
    end
    busy = 0;
    for (int c = 0; c < 6; c++) begin
      if (mem_req_valid !== 1'b0) busy++;
      step();
    end
    checkOutput("full.noReqCycles", 32'(busy), 32'd0);
    checkOutput("full.iqValid", {31'd0, iq_out_valid}, 32'd1);
    checkOutput("full.headPc", iq_out_pc, 32'h0);
    iq_out_ready = 1'b1;
    step();
    iq_out_ready = 1'b0;
    checkOutput("full.popIdle", {31'd0, mem_req_valid}, 32'd0);
    step();
    checkOutput("full.reqAfterPop", {31'd0, mem_req_valid}, 32'd1);
    checkOutput("full.reqAddr17", mem_req_addr, 32'h40);
    checkOutput("full.headAfterPop", iq_out_pc, 32'h4);

    // Reset in the middle of an outstanding fetch with a loaded queue.
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midReset.reqValid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("midReset.reqAddr", mem_req_addr, 32'd0);
    checkOutput("midReset.iqValid", {31'd0, iq_out_valid}, 32'd0);
    checkOutput("midReset.iqPc", iq_out_pc, 32'd0);
    waitReq("midReset.refetch");
    checkOutput("midReset.refetchAddr", mem_req_addr, 32'h0);

    // Push and pop together at tail=15, then drain to verify order and wrap.
    doReset();
    for (int k = 0; k < 15; k++) begin
      serveFetch($sformatf("wrap%0d", k), 32'(4 * k), instFor(k), 1'b0, 32'h0, 1, 1'b0);
    end
    serveFetch("wrap15", 32'h3C, instFor(15), 1'b0, 32'h0, 1, 1'b1);
    iq_out_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      checkOutput($sformatf("wrapDrain%0d.pc", k), iq_out_pc, 32'(4 * k));
      checkOutput($sformatf("wrapDrain%0d.inst", k), iq_out_inst, instFor(k));
      step();
    end
    iq_out_ready = 1'b0;
    checkOutput("wrapDrain.empty", {31'd0, iq_out_valid}, 32'd0);
    serveFetch("wrap16", 32'h40, instFor(16), 1'b0, 32'h0, 1, 1'b0);
    checkOutput("wrap16.iqValid", {31'd0, iq_out_valid}, 32'd1);
    checkOutput("wrap16.headPc", iq_out_pc, 32'h40);
    checkOutput("wrap16.headInst", iq_out_inst, instFor(16));

    // Rollback in WAIT_MEM, stale response three cycles later.
    doReset();
    serveFetch("rbW0", 32'h0, instFor(0), 1'b0, 32'h0, 1, 1'b0);
    serveFetch("rbW1", 32'h4, instFor(1), 1'b0, 32'h0, 1, 1'b0);
    waitReq("rbW2");
    rollback = 1'b1;
    rollback_pc = 32'h100;
    step();
    rollback = 1'b0;
    checkOutput("rbWait.iqValid", {31'd0, iq_out_valid}, 32'd0);
    checkOutput("rbWait.reqDrop", {31'd0, mem_req_valid}, 32'd0);
    step();
    checkOutput("rbWait.drainNoReq", {31'd0, mem_req_valid}, 32'd0);
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_inst = 32'hDEADBEEF;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_inst = 32'd0;
    checkOutput("rbWait.staleNotQueued", {31'd0, iq_out_valid}, 32'd0);
    serveFetch("rbWait.restart", 32'h100, 32'h00100093, 1'b0, 32'h0, 1, 1'b0);
    checkOutput("rbWait.headPc", iq_out_pc, 32'h100);
    checkOutput("rbWait.headInst", iq_out_inst, 32'h00100093);

    // Rollback coinciding with the response: dropped, no DRAIN detour.
    doReset();
    waitReq("rbRsp");
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_inst = 32'h12345013;
    rollback = 1'b1;
    rollback_pc = 32'h200;
    step();
    mem_rsp_valid = 1'b0;
    rollback = 1'b0;
    checkOutput("rbRsp.dropped", {31'd0, iq_out_valid}, 32'd0);
    checkOutput("rbRsp.idle", {31'd0, mem_req_valid}, 32'd0);
    step();
    checkOutput("rbRsp.reqValid", {31'd0, mem_req_valid}, 32'd1);
    checkOutput("rbRsp.reqAddr", mem_req_addr, 32'h200);

    // A second rollback while draining only moves the restart PC.
    doReset();
    waitReq("rbDrain");
    rollback = 1'b1;
    rollback_pc = 32'h300;
    step();
    rollback_pc = 32'h340;
    step();
    rollback = 1'b0;
    checkOutput("rbDrain.noReq", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_inst = 32'hBAD00013;
    step();
    mem_rsp_valid = 1'b0;
    checkOutput("rbDrain.staleNotQueued", {31'd0, iq_out_valid}, 32'd0);
    waitReq("rbDrain.restart");
    checkOutput("rbDrain.restartAddr", mem_req_addr, 32'h340);

`ifdef FETCHER_ICACHE_EN
    // Warm 0x0-0xC, roll back to 0x0: four hits on consecutive cycles.
    doReset();
    for (int k = 0; k < 4; k++) begin
      serveFetch($sformatf("icWarm%0d", k), 32'(4 * k), instFor(k), 1'b0, 32'h0, 1, 1'b0);
    end
    rollback = 1'b1;
    rollback_pc = 32'h0;
    step();
    rollback = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("icHit%0d.noReq", k), {31'd0, mem_req_valid}, 32'd0);
      checkOutput($sformatf("icHit%0d.predPc", k), pred_pc, 32'(4 * k));
      checkOutput($sformatf("icHit%0d.predInst", k), pred_inst, instFor(k));
      step();
    end
    checkOutput("icHit.headPc", iq_out_pc, 32'h0);
    checkOutput("icHit.headInst", iq_out_inst, instFor(0));
    waitReq("icMiss");
    checkOutput("icMiss.addr", mem_req_addr, 32'h10);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
